// File: rtl/spart_bus_intf.sv
// SPART processor-bus slave: register decode, read-data drive, receive FIFO,
// transmit holding register and the 16-bit baud divisor.
module spart_bus_intf #(
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] DB_RESET = 16'd650
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iocs,
    input  logic        iorw,
    input  logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic        rda,
    output logic        tbr,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [15:0] db,
    output logic        db_load
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // Bus cycle decode
    logic rd_cyc;
    logic wr_cyc;
    logic data_rd;
    logic status_rd;
    logic data_wr;
    logic db_lo_wr;
    logic db_hi_wr;

    assign rd_cyc    = iocs & iorw;
    assign wr_cyc    = iocs & ~iorw;
    assign data_rd   = rd_cyc & (ioaddr == ADDR_DATA);
    assign status_rd = rd_cyc & (ioaddr == ADDR_STATUS);
    assign data_wr   = wr_cyc & (ioaddr == ADDR_DATA);
    assign db_lo_wr  = wr_cyc & (ioaddr == ADDR_DB_LO);
    assign db_hi_wr  = wr_cyc & (ioaddr == ADDR_DB_HI);

    // Receive FIFO storage and bookkeeping
    logic [7:0]    rx_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          rx_ovr;
    logic          tx_ovr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          rx_drop;

    assign fifo_full  = (count == CW'(RX_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = data_rd & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push       = rx_valid & (~fifo_full | pop);
    assign rx_drop    = rx_valid & fifo_full & ~pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rx_mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rda    <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_next;
            rda    <= (count_next != '0);
            rx_ovr <= (rx_ovr & ~status_rd) | rx_drop;
        end
    end

    // Transmit handshake: tbr=1 means the holding register is free. While it
    // holds a byte (tbr=0) and tx_busy=0, tx_start is high for that cycle; the
    // transmitter takes tx_data on that edge and tbr returns to 1 after it.
    logic tx_load;
    logic tx_drop;

    assign tx_load  = data_wr & tbr;
    assign tx_drop  = data_wr & ~tbr;
    assign tx_start = ~tbr & ~tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbr     <= 1'b1;
            tx_data <= 8'h00;
            tx_ovr  <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_data <= databus;
                tbr     <= 1'b0;
            end else if (tx_start) begin
                tbr     <= 1'b1;
            end
            tx_ovr <= (tx_ovr & ~status_rd) | tx_drop;
        end
    end

    // Baud divisor: the low byte is staged and only takes effect on a high-byte write
    logic [7:0] db_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db      <= DB_RESET;
            db_lo   <= DB_RESET[7:0];
            db_load <= 1'b0;
        end else begin
            db_load <= db_hi_wr;
            if (db_lo_wr) begin
                db_lo <= databus;
            end
            if (db_hi_wr) begin
                db <= {databus, db_lo};
            end
        end
    end

    // Read data mux, combinational from current state
    logic [3:0] count_ext;
    logic [7:0] status_byte;
    logic [7:0] rd_mux;

    assign count_ext   = 4'(count);
    assign status_byte = {1'b0, count_ext[2:0], tx_ovr, rx_ovr, tbr, rda};

    always_comb begin
        rd_mux = 8'h00;
        case (ioaddr)
            ADDR_DATA:   rd_mux = fifo_empty ? 8'h00 : rx_mem[rd_ptr];
            ADDR_STATUS: rd_mux = status_byte;
            ADDR_DB_LO:  rd_mux = db_lo;
            ADDR_DB_HI:  rd_mux = db[15:8];
            default:     rd_mux = 8'h00;
        endcase
    end

    assign databus = rd_cyc ? rd_mux : 8'hzz;

endmodule

// File: tb/tb_spart_bus_intf.sv
// Directed bench for spart_bus_intf: reset, RX FIFO, TX handshake, baud
// divisor and mid-operation reset, with hand-computed expected values.
module tb_spart_bus_intf;

    logic        clk;
    logic        rst;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic        rda;
    logic        tbr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] db;
    logic        db_load;

    logic       bus_oe;
    logic [7:0] bus_drv;

    int n_tests;
    int n_fail;

    // Released bus floats high through the pullup
    assign databus = bus_oe ? bus_drv : 8'hzz;
    pullup (databus);

    spart_bus_intf #(.RX_DEPTH(4), .DB_RESET(16'd650)) dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .db       (db),
        .db_load  (db_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge
    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk) d = databus;
        @(posedge clk) #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_oe = 1'b1; bus_drv = d;
        @(posedge clk) #1;
        iocs = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        @(posedge clk) #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_and_read(input logic [7:0] d, output logic [7:0] q);
        rx_valid = 1'b1; rx_data = d;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        @(negedge clk) q = databus;
        @(posedge clk) #1;
        rx_valid = 1'b0; iocs = 1'b0; iorw = 1'b0;
    endtask

    logic [7:0] rd;
    logic       seen;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b1;
        bus_oe = 1'b0; bus_drv = 8'h00;

        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        check("rst_rda", {15'd0, rda}, 16'd0);
        check("rst_tbr", {15'd0, tbr}, 16'd1);
        check("rst_db", db, 16'd650);
        check("rst_db_load", {15'd0, db_load}, 16'd0);
        check("rst_tx_start", {15'd0, tx_start}, 16'd0);
        check("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        check("rst_bus_rel", {8'h00, databus}, 16'h00FF);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        bus_read(2'b01, rd);
        check("rst_status", {8'h00, rd}, 16'h0002);

        // RX fill past full, then drain
        rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44); rx_push(8'h55);
        check("rx_full_rda", {15'd0, rda}, 16'd1);
        bus_read(2'b01, rd);
        check("rx_ovr_status", {8'h00, rd}, 16'h0047);
        bus_read(2'b00, rd); check("rx_pop0", {8'h00, rd}, 16'h0011);
        bus_read(2'b00, rd); check("rx_pop1", {8'h00, rd}, 16'h0022);
        bus_read(2'b00, rd); check("rx_pop2", {8'h00, rd}, 16'h0033);
        bus_read(2'b00, rd); check("rx_pop3", {8'h00, rd}, 16'h0044);
        check("rx_empty_rda", {15'd0, rda}, 16'd0);
        bus_read(2'b00, rd); check("rx_empty_read", {8'h00, rd}, 16'h0000);
        bus_read(2'b01, rd); check("rx_ovr_cleared", {8'h00, rd}, 16'h0002);

        // Push and pop together at full, then at empty
        rx_push(8'h01); rx_push(8'h02); rx_push(8'h03); rx_push(8'h04);
        push_and_read(8'hAA, rd);
        check("full_pp_head", {8'h00, rd}, 16'h0001);
        bus_read(2'b01, rd); check("full_pp_status", {8'h00, rd}, 16'h0043);
        bus_read(2'b00, rd); check("full_pp_d1", {8'h00, rd}, 16'h0002);
        bus_read(2'b00, rd); check("full_pp_d2", {8'h00, rd}, 16'h0003);
        bus_read(2'b00, rd); check("full_pp_d3", {8'h00, rd}, 16'h0004);
        bus_read(2'b00, rd); check("full_pp_last", {8'h00, rd}, 16'h00AA);
        push_and_read(8'hBB, rd);
        check("empty_pp_read", {8'h00, rd}, 16'h0000);
        bus_read(2'b01, rd); check("empty_pp_status", {8'h00, rd}, 16'h0013);
        bus_read(2'b00, rd); check("empty_pp_data", {8'h00, rd}, 16'h00BB);

        // TX handshake while transmitter busy
        bus_write(2'b00, 8'hA5);
        check("tx_tbr_low", {15'd0, tbr}, 16'd0);
        check("tx_no_start", {15'd0, tx_start}, 16'd0);
        bus_write(2'b00, 8'h3C);
        check("tx_hold_kept", {8'h00, tx_data}, 16'h00A5);
        bus_read(2'b01, rd); check("tx_ovr_status", {8'h00, rd}, 16'h0008);
        tx_busy = 1'b0;
        @(negedge clk);
        check("tx_start_hi", {15'd0, tx_start}, 16'd1);
        check("tx_start_data", {8'h00, tx_data}, 16'h00A5);
        @(posedge clk) #1;
        check("tx_start_once", {15'd0, tx_start}, 16'd0);
        check("tx_tbr_back", {15'd0, tbr}, 16'd1);
        bus_write(2'b00, 8'h5A);
        check("tx_lat1_start", {15'd0, tx_start}, 16'd1);
        check("tx_lat1_data", {8'h00, tx_data}, 16'h005A);
        @(posedge clk) #1;
        check("tx_lat1_done", {14'd0, tx_start, tbr}, 16'd1);

        // Baud divisor staging and commit
        bus_write(2'b10, 8'h45);
        check("db_staged_only", db, 16'd650);
        check("db_no_load", {15'd0, db_load}, 16'd0);
        bus_write(2'b11, 8'h01);
        check("db_commit", db, 16'h0145);
        check("db_load_hi", {15'd0, db_load}, 16'd1);
        @(posedge clk) #1;
        check("db_load_pulse", {15'd0, db_load}, 16'd0);
        bus_read(2'b10, rd); check("db_lo_read", {8'h00, rd}, 16'h0045);
        bus_read(2'b11, rd); check("db_hi_read", {8'h00, rd}, 16'h0001);
        bus_write(2'b11, 8'h02);
        check("db_b2b_1", {db_load, db[14:0]}, 16'h8245);
        bus_write(2'b11, 8'h03);
        check("db_b2b_2", {db_load, db[14:0]}, 16'h8345);
        @(posedge clk) #1;
        check("db_b2b_end", {15'd0, db_load}, 16'd0);

        // Ignored accesses
        bus_write(2'b01, 8'hFF);
        bus_read(2'b01, rd); check("status_wr_ignored", {8'h00, rd}, 16'h0002);
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b01;
        @(negedge clk);
        check("bus_rel_no_cs", {8'h00, databus}, 16'h00FF);
        @(posedge clk) #1;
        iorw = 1'b0;

        // Reset with FIFO data and a held TX byte
        tx_busy = 1'b1;
        rx_push(8'hC1); rx_push(8'hC2);
        bus_write(2'b00, 8'h77);
        check("pre_rst_tbr", {14'd0, rda, tbr}, 16'h0002);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rda_tbr", {14'd0, rda, tbr}, 16'h0001);
        check("mid_rst_tx_data", {8'h00, tx_data}, 16'h0000);
        check("mid_rst_db", db, 16'd650);
        check("mid_rst_tx_start", {15'd0, tx_start}, 16'd0);
        tx_busy = 1'b0;
        @(negedge clk) rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        check("post_rst_no_start", {15'd0, seen}, 16'd0);
        @(posedge clk) #1;
        bus_read(2'b01, rd); check("post_rst_status", {8'h00, rd}, 16'h0002);
        bus_read(2'b00, rd); check("post_rst_fifo", {8'h00, rd}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_bus_intf.md
Name: spart_bus_intf

Overview:
- SPART-side processor bus slave; directly downstream of `driver`, which sources `iocs`/`iorw`/`ioaddr` and shares `databus`.
- Decodes bus cycles and drives the bidirectional data bus on reads.
- Buffers received bytes in a small FIFO and holds one transmit byte for the transmitter.
- Owns the 16-bit baud divisor registers and generates the `rda`/`tbr` flags seen by `driver`.

Parameters:
- RX_DEPTH, 4, receive FIFO depth in entries (power of 2, 2..8).
- DB_RESET, 16'd650, baud divisor value after reset (4800 baud, 50 MHz, 16x oversample).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- iocs  input  1  chip select from `driver`.
- iorw  input  1  1 = read cycle, 0 = write cycle.
- ioaddr  input  2  register select.
- databus  inout  8  shared bus; driven only during a selected read.
- rda  output  1  receive data available.
- tbr  output  1  transmit buffer ready.
- rx_data  input  8  byte from receiver.
- rx_valid  input  1  one-cycle strobe: rx_data valid.
- tx_data  output  8  byte to transmitter.
- tx_start  output  1  one-cycle strobe: transmitter takes tx_data.
- tx_busy  input  1  transmitter shifting; no tx_start allowed.
- db  output  16  current baud divisor.
- db_load  output  1  one-cycle strobe: db just updated.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - FIFO empty; count=0; rda=0; tbr=1.
  - tx_start=0; tx_data=8'h00.
  - db=DB_RESET; staged low byte=DB_RESET[7:0]; db_load=0.
  - Both overrun flags cleared; databus released (Z).
  - Reset mid-transfer discards all buffered data.
- **Address map:** a cycle is active in any clock cycle with iocs=1.
  - 00 read: RX FIFO head.
  - 00 write: TX holding register.
  - 01 read: status. 01 write: ignored.
  - 10 read: staged low byte. 10 write: stage low byte.
  - 11 read: db[15:8]. 11 write: commit divisor.
- **Bus drive:** databus = read mux when iocs=1 and iorw=1; otherwise Z. The read mux is combinational from current state (same-cycle data).
- **Status byte:** {1'b0, count[2:0], tx_ovr, rx_ovr, tbr, rda}.
  - A status read clears rx_ovr and tx_ovr at the end of that cycle; the read itself returns the pre-clear values.
- **RX FIFO:**
  - rx_valid pushes rx_data.
  - A read of 00 pops one entry per active clock cycle.
  - rda = (count != 0), registered, and reflects count after the edge.
  - Read while empty: returns 8'h00, no pop, no flag change.
  - Push while full with no pop in the same cycle: byte dropped, rx_ovr=1.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: the byte is stored; the read returns 8'h00.
  - Pointers wrap modulo RX_DEPTH.
- **TX path:**
  - A write to 00 with tbr=1 loads the holding register; tbr=0 next cycle.
  - A write to 00 with tbr=0 drops the byte and sets tx_ovr=1.
  - Handoff: when the holding register is full and tx_busy=0, assert tx_start for exactly one cycle with tx_data = held byte. tbr returns to 1 on the following cycle.
  - Minimum write-to-tx_start latency: 1 cycle.
  - tx_data holds its value until the next load.
- **Baud:**
  - A write to 10 stages the low byte only; db does not change.
  - A write to 11 sets db = {databus, staged low} on that edge, and db_load=1 for the next cycle only.
  - Back-to-back writes to 11 give one db_load pulse per write.
- Write cycles sample databus at the clock edge while iocs=1 and iorw=0.
- Any ioaddr/iorw combination not listed above has no effect.

Test Plan:
- **Reset defaults:** rst=0 then 1 → rda=0, tbr=1, db=16'd650, databus=Z, status read = 8'h02.
- **RX FIFO fill and drain:** push 8'h11, 22, 33, 44, then 8'h55 → status = 8'h47 (count 4, rx_ovr=1, tbr=1, rda=1). Four reads of 00 return 11, 22, 33, 44; rda=0 afterwards. A fifth read returns 8'h00. A second status read shows rx_ovr=0.
- **Simultaneous push and pop at full:** FIFO full, rx_valid=1 with 8'hAA during a read of 00 → head returned, count stays 4, rx_ovr stays 0, 8'hAA is the last entry.
- **TX handshake:**
  - tx_busy=1, write 8'hA5 to 00 → tbr=0, no tx_start.
  - Second write 8'h3C → tx_ovr=1, byte dropped.
  - tx_busy falls to 0 → one-cycle tx_start with tx_data=8'hA5, tbr=1 next cycle.
- **Baud divisor:**
  - Write 8'h45 to 10 → db still 16'd650.
  - Write 8'h01 to 11 → db=16'h0145 and db_load high for exactly one cycle.
  - Reading 10 returns 8'h45; reading 11 returns 8'h01.
- **Reset mid-operation:** assert rst with 2 bytes in the FIFO and the TX holding register full → all outputs return to reset values asynchronously, with no tx_start after release.
